muldiv_hilo: RTL
================

MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 SHALL have port clk_cpu, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk_cpu.
REQ-003 SHALL have port req_valid, input, 1 bit: an operation request is present.
REQ-004 SHALL have port req_op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are ignored.
REQ-005 SHALL have port rs, input, 32 bits: the first operand (dividend or multiplicand), or the move-to data for MTHI/MTLO.
REQ-006 SHALL have port rt, input, 32 bits: the second operand (divisor or multiplier).
REQ-007 SHALL have port req_ready, output, 1 bit: equals ~busy.
REQ-008 SHALL have port busy, output, 1 bit: an iterative operation is in progress; the pipeline stalls on MFHI/MFLO/MULT/DIV while this is high.
REQ-009 SHALL have port hilo_q, output, 64 bits: {HI, LO}, registered.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse in the cycle HI/LO is updated by a mult/div.

Function
REQ-011 SHALL accept a request on an edge where req_valid && req_ready; when req_ready is low, the request is ignored (no queueing).
REQ-012 SHALL write MTHI/MTLO on the accepting edge: MTHI sets HI=rs, MTLO sets LO=rs; the other half is unchanged, busy stays 0, and done is not pulsed.
REQ-013 SHALL implement the FSM states IDLE, MUL, DIV and FIX; on accept, IDLE goes to MUL (MULT/MULTU) or DIV (DIV/DIVU), latching operand magnitudes and the sign flags.
REQ-014 SHALL perform one shift-add step per cycle in MUL and one restoring subtract-shift step per cycle in DIV, with a 5-bit step counter; after 32 steps the FSM goes to FIX.
REQ-015 SHALL, in FIX, apply sign correction, write HI/LO, assert done for exactly that cycle, and return to IDLE.
REQ-016 SHALL hold busy high from the edge after accept through the FIX cycle inclusive, giving 34 cycles from accept edge to the cycle new hilo_q is visible.
REQ-017 SHALL produce, for MULT, the full 64-bit two's-complement product; for MULTU, the 64-bit unsigned product.
REQ-018 SHALL produce, for DIV, LO = quotient truncated toward zero and HI = remainder with the sign of the dividend; for DIVU, the unsigned quotient and remainder.
REQ-019 SHALL, on divide by zero (rt=0), give LO=32'hFFFFFFFF and HI=rs for both DIV and DIVU, still taking full latency.
REQ-020 SHALL, for DIV of 32'h80000000 by 32'hFFFFFFFF, give LO=32'h80000000 and HI=0.
REQ-021 SHALL leave HI/LO unchanged until FIX, so hilo_q shows old values while busy.
REQ-022 SHALL take no action for invalid codes 6-7, even when accepted.

Reset
REQ-023 SHALL, while reset=1 (including mid-operation), set state=IDLE, hilo_q=0, busy=0, done=0, and clear the counter; any in-flight operation is discarded.
REQ-024 SHALL ignore req_valid in the same cycle as reset.

Configuration
REQ-025 SHALL, with MULDIV_FAST_MULT_EN defined, compute MULT/MULTU in a single cycle: HI/LO written on the accepting edge, busy stays 0, done pulses the following cycle, and the MUL state is unused; DIV is unaffected.
REQ-026 SHALL, without MULDIV_FAST_MULT_EN, use the iterative 34-cycle MUL path of REQ-014 to REQ-016.

Verification
REQ-027 SHALL cover MULT rs=32'hFFFFFFFE (-2), rt=3: hilo_q=64'hFFFFFFFF_FFFFFFFA, done after 34 cycles (iterative build).
REQ-028 SHALL cover DIV rs=-7, rt=2: LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU rs=7, rt=2: LO=3, HI=1.
REQ-029 SHALL cover DIVU rs=32'h1234, rt=0: LO=32'hFFFFFFFF, HI=32'h1234; and DIV 32'h80000000 by -1: LO=32'h80000000, HI=0.
REQ-030 SHALL cover MTHI 32'hA5A5A5A5, then MTLO 32'h5A5A5A5A: hilo_q=64'hA5A5A5A5_5A5A5A5A, busy never high, no done pulse.
REQ-031 SHALL cover a second DIV request 10 cycles into a DIV: it is ignored (req_ready=0), and the result reflects only the first operation.
REQ-032 SHALL cover reset asserted at step 15 of a MULTU: the next cycle shows busy=0, hilo_q=0, and no done; a fresh MULTU 5*6 then gives hilo_q=30.

Source files
------------

// File: rtl/muldiv_hilo.sv
// HI/LO multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MULT_EN for a single-cycle MULT/MULTU; DIV stays iterative.
module muldiv_hilo (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        req_ready,
  output logic        busy,
  output logic [63:0] hilo_q,
  output logic        done
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  state_t      state_r;
  logic [63:0] acc_r;
  logic [31:0] opa_r;
  logic [4:0]  step_r;
  logic        neg_lo_r;
  logic        neg_hi_r;
  logic        is_div_r;
  logic        divz_r;
  logic        busy_r;
  logic        done_r;
  logic [63:0] hilo_r;

  logic        accept_s;
  logic        sign_a_s;
  logic        sign_b_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_trial_s;
  logic [63:0] div_next_s;
  logic [63:0] fix_hilo_s;
`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod_s;
`endif

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    mag32 = neg ? (~x + 32'd1) : x;
  endfunction

  assign req_ready = ~busy_r;
  assign busy      = busy_r;
  assign hilo_q    = hilo_r;
  assign done      = done_r;

  // Accept decode, one multiply/divide step, and final sign correction.
  always_comb begin
    accept_s = req_valid && !busy_r;
    if (req_op == OP_MULT || req_op == OP_DIV) begin
      sign_a_s = rs[31];
      sign_b_s = rt[31];
    end else begin
      sign_a_s = 1'b0;
      sign_b_s = 1'b0;
    end
    // acc holds {partial product, remaining multiplier bits}, shifting right.
    mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opa_r} : 33'd0);
    mul_next_s = {mul_sum_s, acc_r[31:1]};
    // acc holds {remainder, dividend/quotient bits}, shifting left.
    div_trial_s = acc_r[63:31] - {1'b0, opa_r};
    if (!div_trial_s[32]) begin
      div_next_s = {div_trial_s[31:0], acc_r[30:0], 1'b1};
    end else begin
      div_next_s = {acc_r[62:0], 1'b0};
    end
    if (is_div_r) begin
      fix_hilo_s[63:32] = neg_hi_r ? (~acc_r[63:32] + 32'd1) : acc_r[63:32];
      if (divz_r) begin
        fix_hilo_s[31:0] = 32'hFFFF_FFFF;
      end else begin
        fix_hilo_s[31:0] = neg_lo_r ? (~acc_r[31:0] + 32'd1) : acc_r[31:0];
      end
    end else begin
      fix_hilo_s = neg_lo_r ? (~acc_r + 64'd1) : acc_r;
    end
`ifdef MULDIV_FAST_MULT_EN
    fast_prod_s = {{32{sign_a_s}}, rs} * {{32{sign_b_s}}, rt};
`endif
  end

  // Control FSM, operand/accumulator datapath and HI/LO registers.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      acc_r    <= 64'd0;
      opa_r    <= 32'd0;
      step_r   <= 5'd0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      is_div_r <= 1'b0;
      divz_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hilo_r   <= 64'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (req_op)
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
                hilo_r <= fast_prod_s;
                done_r <= 1'b1;
`else
                state_r  <= ST_MUL;
                busy_r   <= 1'b1;
                acc_r    <= {32'd0, mag32(rt, sign_b_s)};
                opa_r    <= mag32(rs, sign_a_s);
                neg_lo_r <= sign_a_s ^ sign_b_s;
                neg_hi_r <= 1'b0;
                is_div_r <= 1'b0;
                divz_r   <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state_r  <= ST_DIV;
                busy_r   <= 1'b1;
                acc_r    <= {32'd0, mag32(rs, sign_a_s)};
                opa_r    <= mag32(rt, sign_b_s);
                neg_lo_r <= sign_a_s ^ sign_b_s;
                neg_hi_r <= sign_a_s;
                is_div_r <= 1'b1;
                divz_r   <= (rt == 32'd0);
              end
              OP_MTHI: hilo_r[63:32] <= rs;
              OP_MTLO: hilo_r[31:0]  <= rs;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          acc_r  <= mul_next_s;
          step_r <= step_r + 5'd1;
          if (step_r == 5'd31) begin
            state_r <= ST_FIX;
          end
        end
        ST_DIV: begin
          acc_r  <= div_next_s;
          step_r <= step_r + 5'd1;
          if (step_r == 5'd31) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          hilo_r  <= fix_hilo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          step_r  <= 5'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          step_r  <= 5'd0;
        end
      endcase
    end
  end

endmodule
